// File: rtl/mod5_serial_sched_pkg.sv
// Shared types and the mod-5 remainder step for the serial divisibility scheduler.
package mod5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MOD_BASE = 5;

    // Returns (2*rem + b) mod 5. The input is at most 9, so one conditional subtract is enough.
    function automatic logic [2:0] next_rem(input logic [2:0] rem, input logic b);
        logic [3:0] t;
        t = {rem, b};
        if (t >= 4'(MOD_BASE)) begin
            return 3'(t - 4'(MOD_BASE));
        end
        return t[2:0];
    endfunction

endpackage

// File: rtl/mod5_serial_sched_core.sv
// Remainder register: folds in one bit per enabled cycle and keeps the running value mod 5.
module mod5_serial_core
    import mod5_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [2:0] rem
);

    logic [2:0] rem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= 3'd0;
        end else if (clr) begin
            rem_q <= 3'd0;
        end else if (en) begin
            rem_q <= next_rem(rem_q, bit_in);
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/mod5_serial_sched.sv
// Round-robin scheduler that tests each accepted word for divisibility by 5, one bit per cycle.
// Define MOD5_REM_OUT_EN to add the resp_rem output port.
module mod5_serial_sched
    import mod5_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic                  resp_div,
    output logic                  busy
`ifdef MOD5_REM_OUT_EN
    ,
    output logic [2:0]            resp_rem
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             resp_valid_q;

    logic             grant_any;
    logic [IDW-1:0]   win;
    logic             accept;
    logic [2:0]       rem;

    // Search starts one past the last granted requester.
    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[(int'(last_q) + 1 + k) % NREQ]) begin
                grant_any = 1'b1;
                win       = IDW'((int'(last_q) + 1 + k) % NREQ);
            end
        end
    end

    assign accept    = rst_n && (state_q == IDLE) && grant_any;
    assign req_ready = accept ? (NREQ'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= IDW'(NREQ - 1);
            id_q         <= '0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        shreg_q <= req_data[int'(win)*WIDTH +: WIDTH];
                        id_q    <= win;
                        last_q  <= win;
                        cnt_q   <= CW'(WIDTH - 1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_q << 1;
                    if (cnt_q == '0) begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    mod5_serial_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (accept),
        .en     (state_q == SHIFT),
        .bit_in (shreg_q[WIDTH-1]),
        .rem    (rem)
    );

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_div   = resp_valid_q && (rem == 3'd0);
    assign busy       = (state_q != IDLE);

`ifdef MOD5_REM_OUT_EN
    assign resp_rem = resp_valid_q ? rem : 3'd0;
`endif

endmodule
